// File: rtl/odd_issue_sched_pkg.sv
// Shared definitions for the odd-pipe issue scheduler: unit encoding,
// per-unit writeback latencies and the writeback-slot count.
package odd_issue_sched_pkg;

    typedef enum logic [1:0] {
        UNIT_PERM  = 2'd0,
        UNIT_LS    = 2'd1,
        UNIT_BR    = 2'd2,
        UNIT_UNDEF = 2'd3
    } unit_e;

    localparam int         NUM_SLOTS = 6;
    localparam logic [2:0] LAT_BR    = 3'd1;
    localparam logic [2:0] LAT_PERM  = 3'd4;
    localparam logic [2:0] LAT_LS    = 3'd6;

    // Accept-to-writeback latency; the undefined unit code behaves as Perm.
    function automatic logic [2:0] unit_latency(input logic [1:0] unit);
        unit_e u;
        u = unit_e'(unit);
        case (u)
            UNIT_BR: return LAT_BR;
            UNIT_LS: return LAT_LS;
            default: return LAT_PERM;
        endcase
    endfunction

    // One-hot slot mask for "lat cycles ahead" (slot k lives in bit k-1).
    function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [2:0] lat);
        logic [NUM_SLOTS-1:0] one;
        one = NUM_SLOTS'(1);
        return one << (lat - 3'd1);
    endfunction

endpackage

// File: rtl/odd_issue_sched_wb_slot_tracker.sv
// Writeback-slot reservation shift register. Every edge the vector moves one
// slot closer to writeback; a set request marks slot set_lat of the shifted
// vector. query_busy looks at the slot an accept this cycle would claim,
// i.e. slot query_lat after this edge's shift (current bit query_lat).
module odd_issue_sched_wb_slot_tracker
    import odd_issue_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           query_lat,
    output logic                 query_busy,
    input  logic                 set_en,
    input  logic [2:0]           set_lat,
    output logic [NUM_SLOTS-1:0] resv_vec
);

    logic [NUM_SLOTS-1:0] resv_q;
    logic [NUM_SLOTS-1:0] resv_d;
    logic [7:0]           resv_ext;

    // Conflict query: zero-extended so the longest latency never sees a hit.
    always_comb begin
        resv_ext   = 8'(resv_q);
        query_busy = resv_ext[query_lat];
    end

    // Next vector: shift toward writeback, then add the new reservation.
    always_comb begin
        resv_d = resv_q >> 1;
        if (set_en) begin
            resv_d = resv_d | slot_onehot(set_lat);
        end
    end

    // Reservation register; reset abandons every outstanding slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resv_q <= '0;
        end else begin
            resv_q <= resv_d;
        end
    end

    assign resv_vec = resv_q;

endmodule

// File: rtl/odd_issue_sched.sv
// Odd-pipe issue scheduler: accepts one decoded instruction per cycle unless
// a flush is active or its writeback slot is already taken, then registers
// the fields toward the RF stage.
// Optional build macro: ODD_SCHED_PERF_EN adds the saturating stall_cnt output.
//
// Handshake: an instruction transfers on a cycle where in_valid && in_ready.
// in_ready depends only on flush, reset, in_reg_write, in_unit and resv_vec
// (never on in_valid); an offered instruction that is not taken is held by
// upstream and retried.
module odd_issue_sched
    import odd_issue_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [10:0]          in_op,
    input  logic [2:0]           in_format,
    input  logic [1:0]           in_unit,
    input  logic [6:0]           in_rt_addr,
    input  logic                 in_reg_write,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [10:0]          out_op,
    output logic [2:0]           out_format,
    output logic [1:0]           out_unit,
    output logic [6:0]           out_rt_addr,
    output logic                 out_reg_write,
`ifdef ODD_SCHED_PERF_EN
    output logic [15:0]          stall_cnt,
`endif
    output logic [NUM_SLOTS-1:0] resv_vec
);

    logic [2:0] lat;
    logic       slot_busy;
    logic       accept;

    // Ready/accept decode; flush outranks a slot conflict, reset blocks all.
    always_comb begin
        lat      = unit_latency(in_unit);
        in_ready = reset & ~flush & ~(in_reg_write & slot_busy);
        accept   = in_valid & in_ready;
    end

    odd_issue_sched_wb_slot_tracker u_tracker (
        .clk        (clk),
        .reset      (reset),
        .query_lat  (lat),
        .query_busy (slot_busy),
        .set_en     (accept & in_reg_write),
        .set_lat    (lat),
        .resv_vec   (resv_vec)
    );

    // Issue register: pulse out_valid after an accept, hold fields otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid     <= 1'b0;
            out_op        <= '0;
            out_format    <= '0;
            out_unit      <= '0;
            out_rt_addr   <= '0;
            out_reg_write <= 1'b0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                out_op        <= in_op;
                out_format    <= in_format;
                out_unit      <= in_unit;
                out_rt_addr   <= in_rt_addr;
                out_reg_write <= in_reg_write;
            end
        end
    end

`ifdef ODD_SCHED_PERF_EN
    // Stall counter: cycles an instruction waited on a slot conflict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && !flush && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_odd_issue_sched.sv
// Self-checking bench for odd_issue_sched. The reference model books
// writebacks on an absolute-cycle calendar (wb_busy[cycle]) and derives the
// expected ready, reservation vector and issued fields from that calendar.
module tb_odd_issue_sched;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_op;
    logic [2:0]  in_format;
    logic [1:0]  in_unit;
    logic [6:0]  in_rt_addr;
    logic        in_reg_write;
    logic        flush;
    logic        out_valid;
    logic [10:0] out_op;
    logic [2:0]  out_format;
    logic [1:0]  out_unit;
    logic [6:0]  out_rt_addr;
    logic        out_reg_write;
    logic [5:0]  resv_vec;
`ifdef ODD_SCHED_PERF_EN
    logic [15:0] stall_cnt;
    int          exp_stall;
`endif

    int          n_tests;
    int          n_fail;
    int          cyc;
    bit          wb_busy [0:8191];
    logic [23:0] exp_q[$];
    logic [23:0] last_fields;

    odd_issue_sched dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_format     (in_format),
        .in_unit       (in_unit),
        .in_rt_addr    (in_rt_addr),
        .in_reg_write  (in_reg_write),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_op        (out_op),
        .out_format    (out_format),
        .out_unit      (out_unit),
        .out_rt_addr   (out_rt_addr),
        .out_reg_write (out_reg_write),
`ifdef ODD_SCHED_PERF_EN
        .stall_cnt     (stall_cnt),
`endif
        .resv_vec      (resv_vec)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Writeback latency straight from the unit table (code 3 acts as Perm).
    function automatic int model_lat(input logic [1:0] unit);
        if (unit == 2'd2) return 1;
        if (unit == 2'd1) return 6;
        return 4;
    endfunction

    // Bit j set when a writeback is booked j cycles from now.
    function automatic logic [5:0] model_resv();
        logic [5:0] v;
        for (int j = 0; j < 6; j++) v[j] = wb_busy[cyc + j];
        return v;
    endfunction

    function automatic logic [23:0] dut_fields();
        return {out_op, out_format, out_unit, out_rt_addr, out_reg_write};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8192; i++) wb_busy[i] = 1'b0;
        exp_q.delete();
        last_fields = '0;
`ifdef ODD_SCHED_PERF_EN
        exp_stall = 0;
`endif
    endtask

    // One clock cycle: drive at edge+1, check ready before the edge,
    // check registered outputs at edge+1. Returns model accept and DUT ready.
    task automatic drive_cycle(input logic v, input logic [10:0] op, input logic [2:0] fmt,
                               input logic [1:0] unit, input logic [6:0] rt, input logic rw,
                               input logic fl, output logic acc, output logic rdy);
        logic exp_ready;
        int   lat;
        in_valid = v; in_op = op; in_format = fmt; in_unit = unit;
        in_rt_addr = rt; in_reg_write = rw; flush = fl;
        #2;
        lat       = model_lat(unit);
        exp_ready = !fl && !(rw && wb_busy[cyc + lat]);
        rdy       = in_ready;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        acc = v && exp_ready;
        if (acc) begin
            if (rw) wb_busy[cyc + lat] = 1'b1;
            exp_q.push_back({op, fmt, unit, rt, rw});
        end
`ifdef ODD_SCHED_PERF_EN
        if (v && !exp_ready && !fl && exp_stall != 65535) exp_stall++;
`endif
        @(posedge clk);
        cyc++;
        #1;
        check("out_valid", 32'(out_valid), 32'(acc));
        if (acc && exp_q.size() > 0) last_fields = exp_q.pop_front();
        check("out_fields", 32'(dut_fields()), 32'(last_fields));
        check("resv_vec", 32'(resv_vec), 32'(model_resv()));
`ifdef ODD_SCHED_PERF_EN
        check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`endif
    endtask

    task automatic idle(input int n);
        logic a, r;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 11'd0, 3'd0, 2'd0, 7'd0, 1'b0, 1'b0, a, r);
    endtask

    // Asynchronous reset pulse entered at edge+1; outputs must clear at once.
    task automatic pulse_reset();
        in_valid = 1'b1; in_reg_write = 1'b1; in_unit = 2'd0; flush = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_resv", 32'(resv_vec), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_fields", 32'(dut_fields()), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        clear_model();
        @(posedge clk);
        cyc++;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic       a, r;
        logic       have;
        logic [10:0] p_op;
        logic [2:0]  p_fmt;
        logic [1:0]  p_unit;
        logic [6:0]  p_rt;
        logic        p_rw;
        logic        fl;
        n_tests = 0; n_fail = 0; cyc = 0;
        clear_model();
        reset = 1'b0; in_valid = 1'b1; in_op = 11'h7ff; in_format = 3'd5;
        in_unit = 2'd1; in_rt_addr = 7'h55; in_reg_write = 1'b1; flush = 1'b0;
        #2;
        check("reset_resv", 32'(resv_vec), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_fields", 32'(dut_fields()), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // LS at c0, Perm at c2 collides at writeback c6; accepted at c3.
        drive_cycle(1'b1, 11'h101, 3'd1, 2'd1, 7'd10, 1'b1, 1'b0, a, r);
        idle(1);
        drive_cycle(1'b1, 11'h202, 3'd2, 2'd0, 7'd11, 1'b1, 1'b0, a, r);
        check("ls_perm_stall", 32'(r), 32'd0);
        drive_cycle(1'b1, 11'h202, 3'd2, 2'd0, 7'd11, 1'b1, 1'b0, a, r);
        check("ls_perm_accept", 32'(r), 32'd1);
        idle(7);

        // LS at c0, Br at c5 collides at writeback c6; accepted at c6.
        drive_cycle(1'b1, 11'h111, 3'd1, 2'd1, 7'd20, 1'b1, 1'b0, a, r);
        idle(4);
        drive_cycle(1'b1, 11'h333, 3'd3, 2'd2, 7'd21, 1'b1, 1'b0, a, r);
        check("ls_br_stall", 32'(r), 32'd0);
        drive_cycle(1'b1, 11'h333, 3'd3, 2'd2, 7'd21, 1'b1, 1'b0, a, r);
        check("ls_br_accept", 32'(r), 32'd1);
        idle(2);
        check("ls_br_drained", 32'(resv_vec), 32'd0);
        idle(5);

        // Non-writing Perm while its slot is reserved: accepted, no booking.
        drive_cycle(1'b1, 11'h121, 3'd1, 2'd1, 7'd30, 1'b1, 1'b0, a, r);
        idle(1);
        drive_cycle(1'b1, 11'h444, 3'd4, 2'd0, 7'd31, 1'b0, 1'b0, a, r);
        check("rw0_accept", 32'(r), 32'd1);
        check("rw0_shift_only", 32'(resv_vec), 32'(6'b001000));
        idle(7);

        // Flush with free slots: nothing accepted, vector only shifts.
        drive_cycle(1'b1, 11'h555, 3'd5, 2'd1, 7'd40, 1'b1, 1'b0, a, r);
        drive_cycle(1'b1, 11'h556, 3'd5, 2'd0, 7'd41, 1'b1, 1'b1, a, r);
        check("flush_ready", 32'(r), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_resv", 32'(resv_vec), 32'(6'b010000));
        idle(7);

        // Build 101000, reset mid-flight, Perm accepted right after release.
        drive_cycle(1'b1, 11'h061, 3'd6, 2'd1, 7'd50, 1'b1, 1'b0, a, r);
        idle(1);
        drive_cycle(1'b1, 11'h062, 3'd6, 2'd1, 7'd51, 1'b1, 1'b0, a, r);
        check("pre_reset_resv", 32'(resv_vec), 32'(6'b101000));
        pulse_reset();
        drive_cycle(1'b1, 11'h063, 3'd7, 2'd0, 7'd52, 1'b1, 1'b0, a, r);
        check("post_reset_accept", 32'(r), 32'd1);
        idle(7);

        // Back-to-back LS, Perm, Br with no conflicts.
        drive_cycle(1'b1, 11'h071, 3'd0, 2'd1, 7'd60, 1'b1, 1'b0, a, r);
        check("b2b_ls", 32'(r), 32'd1);
        drive_cycle(1'b1, 11'h072, 3'd0, 2'd0, 7'd61, 1'b1, 1'b0, a, r);
        check("b2b_perm", 32'(r), 32'd1);
        drive_cycle(1'b1, 11'h073, 3'd0, 2'd2, 7'd62, 1'b1, 1'b0, a, r);
        check("b2b_br", 32'(r), 32'd1);
        idle(7);

`ifdef ODD_SCHED_PERF_EN
        // Three LS writebacks at c6..c8 stall a Br offered at c5 for 3 cycles.
        pulse_reset();
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b1, 11'h080, 3'd0, 2'd1, 7'(70 + i), 1'b1, 1'b0, a, r);
        idle(2);
        a = 1'b0;
        for (int i = 0; i < 6 && !a; i++)
            drive_cycle(1'b1, 11'h081, 3'd0, 2'd2, 7'd73, 1'b1, 1'b0, a, r);
        check("perf_three_stalls", 32'(stall_cnt), 32'd3);
        idle(7);
`endif

        // Randomized traffic; an offered instruction is held until taken.
        have = 1'b0;
        p_op = '0; p_fmt = '0; p_unit = '0; p_rt = '0; p_rw = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) pulse_reset();
            if (!have && $urandom_range(0, 3) != 0) begin
                have   = 1'b1;
                p_op   = 11'($urandom_range(0, 2047));
                p_fmt  = 3'($urandom_range(0, 7));
                p_unit = 2'($urandom_range(0, 3));
                p_rt   = 7'($urandom_range(0, 127));
                p_rw   = ($urandom_range(0, 4) != 0);
            end
            fl = ($urandom_range(0, 7) == 0);
            drive_cycle(have, p_op, p_fmt, p_unit, p_rt, p_rw, fl, a, r);
            if (a) have = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
